// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32I decode front stage.
//   imm_sel_e    - immediate format code consumed by the extend units
//   OPC_*        - major opcode values (instr[6:0])
//   dec_bundle_t - the full decoded field bundle carried through the stage
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_CSR  = 3'd6
    } imm_sel_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        imm_sel_e    imm_sel;
        logic [11:0] imm_i;
        logic [6:0]  imm_s_hi;
        logic [4:0]  imm_s_lo;
        logic [19:0] imm_uj;
        logic [4:0]  zimm;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational RV32I field splitter.
//   instr - raw 32-bit instruction word
//   dec   - decoded bundle: raw field slices, immediate format, illegal flag
// Field slices are always produced; imm_sel tells downstream which to use.
module instr_field_decode
    import decode_pkg::*;
(
    input  logic [31:0]  instr,
    output dec_bundle_t  dec
);

    always_comb begin
        dec          = '0;
        dec.opcode   = instr[6:0];
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.funct3   = instr[14:12];
        dec.funct7   = instr[31:25];
        dec.imm_i    = instr[31:20];
        dec.imm_s_hi = instr[31:25];
        dec.imm_s_lo = instr[11:7];
        dec.imm_uj   = instr[31:12];
        dec.zimm     = instr[19:15];
        dec.imm_sel  = IMM_NONE;
        dec.illegal  = 1'b0;

        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                  dec.imm_sel = IMM_U;
            OPC_JAL:                             dec.imm_sel = IMM_J;
            OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM:  dec.imm_sel = IMM_I;
            OPC_STORE:                           dec.imm_sel = IMM_S;
            OPC_BRANCH:                          dec.imm_sel = IMM_B;
            OPC_OP:                              dec.imm_sel = IMM_NONE;
            OPC_JALR: begin
                if (instr[14:12] != 3'b000) dec.illegal = 1'b1;
                else                        dec.imm_sel = IMM_I;
            end
            OPC_SYSTEM: begin
                // funct3=100 is unassigned; 101/110/111 are the CSR*I forms
                // whose rs1 field is a zero-extended immediate.
                if (instr[14:12] == 3'b100) dec.illegal = 1'b1;
                else if (instr[14])         dec.imm_sel = IMM_CSR;
                else                        dec.imm_sel = IMM_I;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Compressed / non-32-bit encodings are not handled by this stage.
        if (instr[1:0] != 2'b11) dec.illegal = 1'b1;
        if (dec.illegal)         dec.imm_sel = IMM_NONE;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32I decode front stage with a one-entry
// skid buffer.
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - drop all held entries at the next edge
//   in_valid/in_ready     - fetch side handshake; in_instr, in_pc payload
//   out_valid/out_ready   - downstream handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7
//                         - decoded fields of the head entry
//   out_imm_sel           - immediate format code (decode_pkg::imm_sel_e)
//   out_imm_i/_s_hi/_s_lo/_uj, out_zimm - raw immediate slices
//   out_illegal           - unrecognised encoding
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; valid never depends on ready. in_ready is purely !skid_valid, so
// it is a register output with no path from out_ready.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [2:0]       out_imm_sel,
    output logic [11:0]      out_imm_i,
    output logic [6:0]       out_imm_s_hi,
    output logic [4:0]       out_imm_s_lo,
    output logic [19:0]      out_imm_uj,
    output logic [4:0]       out_zimm,
    output logic             out_illegal
);

    dec_bundle_t       dec_in;
    dec_bundle_t       main_q;
    dec_bundle_t       skid_q;
    logic [PC_W-1:0]   main_pc;
    logic [PC_W-1:0]   skid_pc;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              pop;

    instr_field_decode u_field_decode (
        .instr (in_instr[31:0]),
        .dec   (dec_in)
    );

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign pop       = main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_pc    <= '0;
            skid_pc    <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || pop) begin
            // Head slot frees up: the older skid entry goes first. An input
            // cannot be accepted while skid is full (in_ready is low), so
            // the skid refill case never coincides with a skid drain.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_pc    <= skid_pc;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec_in;
                main_pc    <= in_pc;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            // Head is stalled: park the new entry in the skid slot.
            skid_q     <= dec_in;
            skid_pc    <= in_pc;
            skid_valid <= 1'b1;
        end
    end

    assign out_pc       = main_pc;
    assign out_opcode   = main_q.opcode;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_funct3   = main_q.funct3;
    assign out_funct7   = main_q.funct7;
    assign out_imm_sel  = main_q.imm_sel;
    assign out_imm_i    = main_q.imm_i;
    assign out_imm_s_hi = main_q.imm_s_hi;
    assign out_imm_s_lo = main_q.imm_s_lo;
    assign out_imm_uj   = main_q.imm_uj;
    assign out_zimm     = main_q.zimm;
    assign out_illegal  = main_q.illegal;

endmodule
